// File: rtl/inst_axi_bridge_if.sv
// Fetch-side request/response signals and the AXI4 read channels of the instruction bridge.
// The slave modport is the bridge; the master modport is whatever drives it (core plus memory).
interface inst_axi_bridge_if;
  // Fetch side
  logic        inst_req;
  logic        inst_cache;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        cancel;

  // AXI read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;

  // AXI read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [31:0] perfcnt_inst_busy;

  modport slave (
    input  inst_req, inst_cache, inst_addr, cancel,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    output inst_addr_ok, inst_rdata, inst_data_ok,
    output arid, araddr, arlen, arsize, arburst, arcache, arvalid, rready,
    output perfcnt_inst_busy
  );

  modport master (
    output inst_req, inst_cache, inst_addr, cancel,
    output arready, rid, rdata, rresp, rlast, rvalid,
    input  inst_addr_ok, inst_rdata, inst_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arcache, arvalid, rready,
    input  perfcnt_inst_busy
  );
endinterface

// File: rtl/inst_axi_bridge.sv
// Instruction fetch to AXI4 read bridge: up to DEPTH in-order outstanding single-beat reads,
// with a cancel that discards every response still in flight.
module inst_axi_bridge #(
  parameter int         DEPTH = 4,
  parameter logic [3:0] ARID  = 4'd0,
  localparam int        CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  inst_axi_bridge_if.slave bus,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] drop_cnt_o
);
  // Handshakes: a fetch is accepted in a cycle with inst_req && inst_addr_ok; AR transfers on
  // arvalid && arready and arvalid never drops before that; an R beat counts on rvalid && rlast
  // (rready is tied high); inst_data_ok is a one-cycle pulse qualifying inst_rdata.

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          arvalid_q;
  logic [31:0]   araddr_q;
  logic [3:0]    arcache_q;
  logic          data_ok_q;
  logic [31:0]   rdata_q;
  logic [31:0]   perf_q;
  logic          addr_fire, r_fire, deliver;

  assign bus.inst_addr_ok = bus.inst_req && !bus.cancel && (cnt_q < CW'(DEPTH)) &&
                            (!arvalid_q || bus.arready);
  assign addr_fire = bus.inst_req && bus.inst_addr_ok;
  assign r_fire    = bus.rvalid && bus.rready && bus.rlast;
  assign deliver   = r_fire && (drop_q == '0) && !bus.cancel;

  always_comb begin
    cnt_d = cnt_q;
    if (addr_fire && !r_fire)
      cnt_d = cnt_q + 1'b1;
    else if (!addr_fire && r_fire && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Cancel blocks acceptance, so the drop count matches the post-cycle outstanding count.
  always_comb begin
    drop_d = drop_q;
    if (bus.cancel)
      drop_d = (r_fire && cnt_q != '0) ? cnt_q - 1'b1 : (r_fire ? '0 : cnt_q);
    else if (r_fire && drop_q != '0)
      drop_d = drop_q - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      drop_q    <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arcache_q <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      perf_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      data_ok_q <= deliver;
      if (deliver)
        rdata_q <= bus.rdata;
      if (addr_fire) begin
        arvalid_q <= 1'b1;
        araddr_q  <= bus.inst_addr;
        arcache_q <= bus.inst_cache ? 4'b1111 : 4'b0000;
      end else if (arvalid_q && bus.arready) begin
        arvalid_q <= 1'b0;
      end
      if (cnt_q != '0)
        perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.arid              = ARID;
  assign bus.araddr            = araddr_q;
  assign bus.arlen             = 8'd0;
  assign bus.arsize            = 3'd2;
  assign bus.arburst           = 2'b01;
  assign bus.arcache           = arcache_q;
  assign bus.arvalid           = arvalid_q;
  assign bus.rready            = 1'b1;
  assign bus.inst_data_ok      = data_ok_q;
  assign bus.inst_rdata        = rdata_q;
  assign bus.perfcnt_inst_busy = perf_q;
  assign cnt_o                 = cnt_q;
  assign drop_cnt_o            = drop_q;
endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge with DEPTH=4; every expected value is worked out by hand.
module tb_inst_axi_bridge;
  logic       clk;
  logic       resetn;
  logic [2:0] cnt_o;
  logic [2:0] drop_cnt_o;
  int         tests_run;
  int         tests_failed;
  int         accepts;

  inst_axi_bridge_if bus_if ();

  inst_axi_bridge #(.DEPTH(4), .ARID(4'd0)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus_if),
    .cnt_o      (cnt_o),
    .drop_cnt_o (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; registered outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.inst_req   = 1'b0;
    bus_if.inst_cache = 1'b0;
    bus_if.inst_addr  = 32'h0;
    bus_if.cancel     = 1'b0;
    bus_if.rvalid     = 1'b0;
    bus_if.rlast      = 1'b0;
    bus_if.rdata      = 32'h0;
    bus_if.rid        = 4'd0;
    bus_if.rresp      = 2'b00;
  endtask

  task automatic set_beat(input logic [31:0] data);
    bus_if.rvalid = 1'b1;
    bus_if.rlast  = 1'b1;
    bus_if.rdata  = data;
  endtask

  task automatic clr_beat();
    bus_if.rvalid = 1'b0;
    bus_if.rlast  = 1'b0;
  endtask

  // One accepted fetch followed by its R beat three cycles later; busy counter grows by 3.
  task automatic single_fetch(input string tag, input logic [31:0] base_perf);
    bus_if.inst_req   = 1'b1;
    bus_if.inst_addr  = 32'h1FC0_0000;
    bus_if.inst_cache = 1'b0;
    bus_if.arready    = 1'b1;
    #1;
    check_eq({tag, "_addr_ok"}, 32'(bus_if.inst_addr_ok), 32'd1);
    tick();
    bus_if.inst_req = 1'b0;
    check_eq({tag, "_arvalid"}, 32'(bus_if.arvalid), 32'd1);
    check_eq({tag, "_araddr"}, bus_if.araddr, 32'h1FC0_0000);
    check_eq({tag, "_arcache"}, 32'(bus_if.arcache), 32'h0);
    check_eq({tag, "_cnt1"}, 32'(cnt_o), 32'd1);
    tick();
    check_eq({tag, "_arvalid_clr"}, 32'(bus_if.arvalid), 32'd0);
    tick();
    set_beat(32'h3C08_BFC0);
    bus_if.rresp = 2'b10;
    #1;
    check_eq({tag, "_no_early_ok"}, 32'(bus_if.inst_data_ok), 32'd0);
    tick();
    clr_beat();
    bus_if.rresp = 2'b00;
    check_eq({tag, "_data_ok"}, 32'(bus_if.inst_data_ok), 32'd1);
    check_eq({tag, "_rdata"}, bus_if.inst_rdata, 32'h3C08_BFC0);
    check_eq({tag, "_cnt0"}, 32'(cnt_o), 32'd0);
    check_eq({tag, "_perf"}, bus_if.perfcnt_inst_busy, base_perf + 32'd3);
    tick();
    check_eq({tag, "_ok_pulse"}, 32'(bus_if.inst_data_ok), 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    resetn       = 1'b0;
    bus_if.arready = 1'b0;
    idle_inputs();
    tick();
    tick();
    // Reset values and constant fields
    check_eq("rst_arvalid", 32'(bus_if.arvalid), 32'd0);
    check_eq("rst_araddr", bus_if.araddr, 32'd0);
    check_eq("rst_arcache", 32'(bus_if.arcache), 32'd0);
    check_eq("rst_cnt", 32'(cnt_o), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt_o), 32'd0);
    check_eq("rst_data_ok", 32'(bus_if.inst_data_ok), 32'd0);
    check_eq("rst_rdata", bus_if.inst_rdata, 32'd0);
    check_eq("rst_perf", bus_if.perfcnt_inst_busy, 32'd0);
    check_eq("const_arid", 32'(bus_if.arid), 32'd0);
    check_eq("const_arlen", 32'(bus_if.arlen), 32'd0);
    check_eq("const_arsize", 32'(bus_if.arsize), 32'd2);
    check_eq("const_arburst", 32'(bus_if.arburst), 32'd1);
    check_eq("const_rready", 32'(bus_if.rready), 32'd1);
    resetn = 1'b1;
    tick();

    single_fetch("single", 32'd0);

    // Backpressure: one accept while arready is low, address held stable
    bus_if.arready    = 1'b0;
    bus_if.inst_req   = 1'b1;
    bus_if.inst_cache = 1'b1;
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      bus_if.inst_addr = 32'h0000_1000 + 32'(i * 4);
      #1;
      if (bus_if.inst_addr_ok) accepts++;
      tick();
    end
    check_eq("bp_accepts", 32'(accepts), 32'd1);
    check_eq("bp_araddr", bus_if.araddr, 32'h0000_1000);
    check_eq("bp_arcache", 32'(bus_if.arcache), 32'hF);
    check_eq("bp_arvalid", 32'(bus_if.arvalid), 32'd1);
    check_eq("bp_cnt", 32'(cnt_o), 32'd1);

    // Release AR: accepts until the outstanding count reaches DEPTH
    bus_if.arready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_if.inst_addr = 32'h0000_2000 + 32'(i * 4);
      #1;
      if (bus_if.inst_addr_ok) accepts++;
      tick();
    end
    check_eq("full_accepts", 32'(accepts), 32'd4);
    check_eq("full_cnt", 32'(cnt_o), 32'd4);
    check_eq("full_arvalid", 32'(bus_if.arvalid), 32'd0);
    #1;
    check_eq("full_addr_ok", 32'(bus_if.inst_addr_ok), 32'd0);

    // Accept attempt plus return at cnt=4: registered cnt blocks the accept
    set_beat(32'hAAAA_0001);
    #1;
    check_eq("sim4_addr_ok", 32'(bus_if.inst_addr_ok), 32'd0);
    tick();
    check_eq("sim4_cnt", 32'(cnt_o), 32'd3);
    check_eq("sim4_data_ok", 32'(bus_if.inst_data_ok), 32'd1);
    check_eq("sim4_rdata", bus_if.inst_rdata, 32'hAAAA_0001);

    // Accept plus return at cnt=3 leaves cnt unchanged
    set_beat(32'hAAAA_0002);
    bus_if.inst_addr = 32'h0000_3000;
    #1;
    check_eq("sim3_addr_ok", 32'(bus_if.inst_addr_ok), 32'd1);
    tick();
    clr_beat();
    check_eq("sim3_cnt", 32'(cnt_o), 32'd3);
    check_eq("sim3_rdata", bus_if.inst_rdata, 32'hAAAA_0002);
    check_eq("sim3_araddr", bus_if.araddr, 32'h0000_3000);

    // Cancel with 3 outstanding and no beat; request held high is refused
    bus_if.cancel = 1'b1;
    #1;
    check_eq("can_addr_ok", 32'(bus_if.inst_addr_ok), 32'd0);
    tick();
    bus_if.cancel   = 1'b0;
    bus_if.inst_req = 1'b0;
    check_eq("can_drop", 32'(drop_cnt_o), 32'd3);
    check_eq("can_cnt", 32'(cnt_o), 32'd3);
    for (int i = 0; i < 3; i++) begin
      set_beat(32'hDEAD_0000 + 32'(i));
      tick();
      check_eq($sformatf("can_drop_ok%0d", i), 32'(bus_if.inst_data_ok), 32'd0);
    end
    clr_beat();
    check_eq("can_rdata_hold", bus_if.inst_rdata, 32'hAAAA_0002);
    check_eq("can_cnt_done", 32'(cnt_o), 32'd0);
    check_eq("can_drop_done", 32'(drop_cnt_o), 32'd0);
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'h0000_4000;
    tick();
    bus_if.inst_req = 1'b0;
    tick();
    set_beat(32'hC0DE_0004);
    tick();
    clr_beat();
    check_eq("can_new_ok", 32'(bus_if.inst_data_ok), 32'd1);
    check_eq("can_new_rdata", bus_if.inst_rdata, 32'hC0DE_0004);

    // Cancel coinciding with a beat at cnt=2
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'h0000_5000;
    tick();
    bus_if.inst_addr = 32'h0000_5004;
    tick();
    bus_if.inst_req = 1'b0;
    check_eq("cr_cnt2", 32'(cnt_o), 32'd2);
    bus_if.cancel = 1'b1;
    set_beat(32'hBAD0_0001);
    tick();
    bus_if.cancel = 1'b0;
    check_eq("cr_ok0", 32'(bus_if.inst_data_ok), 32'd0);
    check_eq("cr_drop1", 32'(drop_cnt_o), 32'd1);
    check_eq("cr_cnt1", 32'(cnt_o), 32'd1);
    set_beat(32'hBAD0_0002);
    tick();
    clr_beat();
    check_eq("cr_ok1", 32'(bus_if.inst_data_ok), 32'd0);
    check_eq("cr_drop0", 32'(drop_cnt_o), 32'd0);
    check_eq("cr_cnt0", 32'(cnt_o), 32'd0);
    check_eq("cr_rdata_hold", bus_if.inst_rdata, 32'hC0DE_0004);

    // Async reset with 2 outstanding, arvalid high and a data_ok pulse present
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'h0000_6000;
    tick();
    bus_if.inst_addr = 32'h0000_6004;
    tick();
    bus_if.inst_addr = 32'h0000_6008;
    set_beat(32'h1234_5678);
    tick();
    clr_beat();
    bus_if.inst_req = 1'b0;
    check_eq("ar_pre_cnt", 32'(cnt_o), 32'd2);
    check_eq("ar_pre_arvalid", 32'(bus_if.arvalid), 32'd1);
    check_eq("ar_pre_ok", 32'(bus_if.inst_data_ok), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("ar_arvalid", 32'(bus_if.arvalid), 32'd0);
    check_eq("ar_cnt", 32'(cnt_o), 32'd0);
    check_eq("ar_data_ok", 32'(bus_if.inst_data_ok), 32'd0);
    check_eq("ar_perf", bus_if.perfcnt_inst_busy, 32'd0);
    bus_if.inst_req = 1'b1;
    tick();
    check_eq("ar_hold_arvalid", 32'(bus_if.arvalid), 32'd0);
    bus_if.inst_req = 1'b0;
    #2;
    resetn = 1'b1;
    tick();
    tick();
    check_eq("ar_idle_perf", bus_if.perfcnt_inst_busy, 32'd0);

    single_fetch("post_rst", 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
